// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared width helpers and limits for the pipelined Karatsuba multiplier.
package karatsuba_pkg;

  localparam int KARATSUBA_MAX_BITS = 64;

  // Width of the low operand half; takes the extra bit when n is odd.
  function automatic int lo_bits(input int n);
    return (n + 1) / 2;
  endfunction

  // Width of the high operand half.
  function automatic int hi_bits(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/karatsuba_half_mul.sv
// karatsuba_half_mul: W x W combinational unsigned multiplier used for the three partial products.
module karatsuba_half_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;

  // Both operands are widened first so the product keeps every bit.
  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/karatsuba_pipe_mul.sv
// karatsuba_pipe_mul: three-stage pipelined one-level Karatsuba multiplier with valid/ready.
// Build macro KARATSUBA_SIGNED_EN: treat a, b and c as two's complement (default: unsigned).
module karatsuba_pipe_mul
  import karatsuba_pkg::*;
#(
  parameter int N_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   c
);

  localparam int LO_BITS = lo_bits(N_BITS);
  localparam int HI_BITS = hi_bits(N_BITS);
  localparam int SW      = LO_BITS + 1;
  localparam int MW      = 2 * SW;
  localparam int MIDW    = N_BITS + 1;
  localparam int CW      = 2 * N_BITS;

  logic                 adv;
  logic [N_BITS-1:0]    mag_a;
  logic [N_BITS-1:0]    mag_b;

  logic                 s1_valid;
  logic [LO_BITS-1:0]   s1_a0;
  logic [LO_BITS-1:0]   s1_b0;
  logic [HI_BITS-1:0]   s1_a1;
  logic [HI_BITS-1:0]   s1_b1;
  logic [SW-1:0]        s1_sa;
  logic [SW-1:0]        s1_sb;

  logic [2*LO_BITS-1:0] p0;
  logic [2*HI_BITS-1:0] p2;
  logic [MW-1:0]        pm;

  logic                 s2_valid;
  logic [2*LO_BITS-1:0] s2_p0;
  logic [2*HI_BITS-1:0] s2_p2;
  logic [MW-1:0]        s2_pm;

  logic [MIDW-1:0]      mid;
  logic [CW-1:0]        prod;
  logic [CW-1:0]        c_next;

  // One global stall: every stage moves only when the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef KARATSUBA_SIGNED_EN
  logic sign_in;
  logic s1_sign;
  logic s2_sign;

  // The most negative value negates to 2^(N_BITS-1), which still fits as an unsigned magnitude.
  assign mag_a   = a[N_BITS-1] ? -a : a;
  assign mag_b   = b[N_BITS-1] ? -b : b;
  assign sign_in = a[N_BITS-1] ^ b[N_BITS-1];
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  // Stage 1: split the operands into halves and form the half sums for the middle product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_a0    <= mag_a[LO_BITS-1:0];
      s1_b0    <= mag_b[LO_BITS-1:0];
      s1_a1    <= mag_a[N_BITS-1:LO_BITS];
      s1_b1    <= mag_b[N_BITS-1:LO_BITS];
      s1_sa    <= SW'(mag_a[LO_BITS-1:0]) + SW'(mag_a[N_BITS-1:LO_BITS]);
      s1_sb    <= SW'(mag_b[LO_BITS-1:0]) + SW'(mag_b[N_BITS-1:LO_BITS]);
`ifdef KARATSUBA_SIGNED_EN
      s1_sign  <= sign_in;
`endif
    end
  end

  karatsuba_half_mul #(.W(LO_BITS)) u_mul_lo (.a(s1_a0), .b(s1_b0), .p(p0));
  karatsuba_half_mul #(.W(HI_BITS)) u_mul_hi (.a(s1_a1), .b(s1_b1), .p(p2));
  karatsuba_half_mul #(.W(SW))      u_mul_md (.a(s1_sa), .b(s1_sb), .p(pm));

  // Stage 2: capture the three half-width products.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_p0    <= p0;
      s2_p2    <= p2;
      s2_pm    <= pm;
`ifdef KARATSUBA_SIGNED_EN
      s2_sign  <= s1_sign;
`endif
    end
  end

  // The cross term a0*b1 + a1*b0 is below 2^(N_BITS+1), so the narrowing here loses nothing.
  assign mid  = MIDW'(s2_pm - MW'(s2_p0) - MW'(s2_p2));
  assign prod = (CW'(s2_p2) << (2 * LO_BITS)) + (CW'(mid) << LO_BITS) + CW'(s2_p0);

`ifdef KARATSUBA_SIGNED_EN
  assign c_next = s2_sign ? -prod : prod;
`else
  assign c_next = prod;
`endif

  // Stage 3: output register; c only loads real results so it stays put across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        c <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_karatsuba_pipe_mul.sv
// tb_karatsuba_pipe_mul: scoreboard bench driving five multiplier instances of different widths.
module tb_karatsuba_pipe_mul;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Free-running 10 ns clock shared by every instance.
  always #5 clk = ~clk;

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 16;
      1:       return 15;
      2:       return 8;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic reportCheck(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int N  = width_of(gi);
    localparam int CW = 2 * N;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] c;
    logic          rand_ready = 1'b0;
    logic          phase_done = 1'b0;
    logic          blk_done = 1'b0;
    logic [N-1:0]  msb;
    logic [CW-1:0] exp_q[$];

    karatsuba_pipe_mul #(.N_BITS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c)
    );

    // Reference product from plain integer arithmetic on the operand values.
    function automatic logic [CW-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      longint vx;
      longint vy;
`ifdef KARATSUBA_SIGNED_EN
      vx = longint'($signed(x));
      vy = longint'($signed(y));
`else
      vx = longint'(x);
      vy = longint'(y);
`endif
      return CW'(vx * vy);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      reportCheck($sformatf("n%0d_%s", N, name), actual, expected);
    endtask

    task automatic nextCycle();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) nextCycle();
    endtask

    // Holds the pair until accepted, then queues its expected product.
    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y);
      int waited;
      waited   = 0;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
        nextCycle();
        waited++;
        @(negedge clk);
      end
      if (in_ready) exp_q.push_back(ref_mul(x, y));
      else checkOutput("accept_timeout", 64'(in_ready), 1);
      nextCycle();
    endtask

    task automatic drainAndCheck();
      int w;
      w          = 0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      in_valid   = 1'b0;
      while (exp_q.size() != 0 && w < 50) begin
        nextCycle();
        w++;
      end
      idle(3);
      checkOutput("drain_empty", 64'(exp_q.size()), 0);
    endtask

    // Feeds one pair into an empty pipe and checks both latency and a known product.
    task automatic runSingle(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic [CW-1:0] expc);
      int edges;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      applyStimulus(x, y);
      in_valid = 1'b0;
      edges    = 1;
      while (!out_valid && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
      end
      checkOutput({name, "_latency"}, 64'(edges), 3);
      checkOutput({name, "_value"}, c, expc);
    endtask

    // Monitor: every presented result is compared with the oldest outstanding expectation.
    always @(negedge clk) begin
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_output", 64'(out_valid), 0);
        end else begin
          checkOutput("product", c, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end

    // Common phase: reset state, corner operands, then random traffic with random back-pressure.
    initial begin
      msb        = '0;
      msb[N-1]   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", 64'(out_valid), 0);
      checkOutput("reset_c", c, 0);
      checkOutput("reset_in_ready", 64'(in_ready), 1);
      nextCycle();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        case (k)
          0:       applyStimulus('0, '0);
          1:       applyStimulus('1, '1);
          2:       applyStimulus('1, '0);
          3:       applyStimulus(N'(1), '1);
          default: applyStimulus(msb, msb);
        endcase
      end
      rand_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        applyStimulus(N'($urandom), N'($urandom));
      end
      drainAndCheck();
      phase_done = 1'b1;
    end

    if (N == 16) begin : g_w16
      // Full-scale latency, stall hold and mid-flight reset.
      initial begin
        wait (phase_done);
`ifdef KARATSUBA_SIGNED_EN
        runSingle("all_ones", '1, '1, 32'h0000_0001);
`else
        runSingle("all_ones", '1, '1, 32'hFFFE_0001);
`endif
        drainAndCheck();
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h00FF);
        applyStimulus(16'h8001, 16'h7FFF);
        applyStimulus(16'h0F0F, 16'hF0F0);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(in_ready), 0);
          checkOutput("stall_out_valid", 64'(out_valid), 1);
          nextCycle();
        end
        drainAndCheck();
        applyStimulus(16'hABCD, 16'h1111);
        applyStimulus(16'h5555, 16'h3333);
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 0);
        checkOutput("flush_c", c, 0);
        checkOutput("flush_in_ready", 64'(in_ready), 1);
        nextCycle();
        applyStimulus(16'h0007, 16'h0009);
        drainAndCheck();
        blk_done = 1'b1;
      end
    end else if (N == 15) begin : g_w15
      // Back-to-back stream must come out at full rate with no gaps.
      initial begin
        wait (phase_done);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        fork
          begin
            for (int k = 1; k <= 20; k++) applyStimulus(N'(k), N'(k + 3));
            in_valid = 1'b0;
          end
          begin
            int w;
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 20) begin
              @(negedge clk);
              w++;
            end
            for (int k = 0; k < 20; k++) begin
              checkOutput("stream_valid", 64'(out_valid), 1);
              @(negedge clk);
            end
          end
        join
        nextCycle();
        drainAndCheck();
        blk_done = 1'b1;
      end
    end else if (N == 8) begin : g_w8
      // Sign-sensitive corner values with known products.
      initial begin
        wait (phase_done);
`ifdef KARATSUBA_SIGNED_EN
        runSingle("m128_m128", 8'h80, 8'h80, 16'h4000);
        runSingle("m128_p1", 8'h80, 8'h01, 16'hFF80);
        runSingle("m1_p5", 8'hFF, 8'h05, 16'hFFFB);
`else
        runSingle("x80_x80", 8'h80, 8'h80, 16'h4000);
        runSingle("x80_x01", 8'h80, 8'h01, 16'h0080);
        runSingle("xff_x05", 8'hFF, 8'h05, 16'h04FB);
`endif
        drainAndCheck();
        blk_done = 1'b1;
      end
    end else begin : g_small
      // Exhaustive sweep of every operand pair for the narrow widths.
      initial begin
        wait (phase_done);
        rand_ready = 1'b1;
        for (int x = 0; x < (1 << N); x++) begin
          for (int y = 0; y < (1 << N); y++) begin
            applyStimulus(N'(x), N'(y));
          end
        end
        drainAndCheck();
        blk_done = 1'b1;
      end
    end
  end

  // Waits for every instance to finish, bounded by a global time limit.
  initial begin
    fork
      wait (g_dut[0].blk_done && g_dut[1].blk_done && g_dut[2].blk_done &&
            g_dut[3].blk_done && g_dut[4].blk_done);
      #400000;
    join_any
    disable fork;
    reportCheck("all_instances_done",
                64'({g_dut[0].blk_done, g_dut[1].blk_done, g_dut[2].blk_done,
                     g_dut[3].blk_done, g_dut[4].blk_done}), 64'h1F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
